// File: rtl/alu_pipe_datapath.sv
// Two-stage register-file/ALU datapath: operand capture with full bypass,
// registered execute stage that retires into the register file and flags.
module alu_pipe_datapath #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              stall,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] a_sel,
    input  logic [ADDR_W-1:0] b_sel,
    input  logic [ADDR_W-1:0] dst_sel,
    input  logic              use_imm,
    input  logic [WIDTH-1:0]  immediate,
    input  logic              wb_en,
    input  logic              flags_en,
    output logic              out_valid,
    output logic [WIDTH-1:0]  result,
    output logic [4:0]        flags,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;

    logic [WIDTH-1:0]  regFile [NREGS];

    logic              exValid;
    logic [WIDTH-1:0]  exA;
    logic [WIDTH-1:0]  exB;
    logic [3:0]        exOp;
    logic [ADDR_W-1:0] exDst;
    logic              exWb;
    logic              exFlagsEn;
    logic              exCin;

    logic              accept;
    logic              retire;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  aluRes;
    logic              aluC;
    logic              aluF;
    logic              aluL;
    logic              aluNop;
    logic              aluWrites;
    logic [4:0]        aluFlags;
    logic              fwdHit;
    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic              cinSel;

    assign issue_ready = !stall;
    assign accept      = issue_valid && !stall;
    assign retire      = exValid && !stall;
    assign dbg_data    = regFile[dbg_sel];

    always_comb begin
        sum    = '0;
        aluRes = '0;
        aluC   = 1'b0;
        aluF   = 1'b0;
        aluL   = 1'b0;
        unique case (exOp)
            OP_ADD, OP_ADDC: begin
                sum    = {1'b0, exA} + {1'b0, exB} + {{WIDTH{1'b0}}, exCin};
                aluRes = sum[MSB:0];
                aluC   = sum[WIDTH];
                aluF   = (exA[MSB] == exB[MSB]) && (aluRes[MSB] != exA[MSB]);
            end
            OP_SUB, OP_CMP: begin
                // The extra top bit of the widened difference is the borrow.
                sum    = {1'b0, exA} - {1'b0, exB};
                aluRes = sum[MSB:0];
                aluC   = sum[WIDTH];
                aluL   = sum[WIDTH];
                aluF   = (exA[MSB] != exB[MSB]) && (aluRes[MSB] != exA[MSB]);
            end
            OP_AND: aluRes = exA & exB;
            OP_OR:  aluRes = exA | exB;
            OP_XOR: aluRes = exA ^ exB;
            OP_MOV: aluRes = exB;
            OP_SHL: begin
                aluRes = {exA[MSB-1:0], 1'b0};
                aluC   = exA[MSB];
            end
            OP_SHR: begin
                aluRes = {1'b0, exA[MSB:1]};
                aluC   = exA[0];
            end
            default: ;
        endcase
    end

    assign aluNop    = exOp > OP_SHR;
    assign aluWrites = !aluNop && (exOp != OP_CMP);
    assign aluFlags  = {aluRes[MSB], aluC, aluF, aluRes == '0, aluL};

    // Forward from the instruction retiring on the same edge as this issue.
    assign fwdHit = retire && exWb && aluWrites;
    assign opA    = (fwdHit && exDst == a_sel) ? aluRes : regFile[a_sel];
    assign opB    = use_imm ? immediate
                  : (fwdHit && exDst == b_sel) ? aluRes : regFile[b_sel];
    assign cinSel = (retire && exFlagsEn && !aluNop) ? aluC : flags[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
            flags     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            exValid   <= 1'b0;
            exA       <= '0;
            exB       <= '0;
            exOp      <= '0;
            exDst     <= '0;
            exWb      <= 1'b0;
            exFlagsEn <= 1'b0;
            exCin     <= 1'b0;
        end else begin
            out_valid <= retire;
            if (retire) begin
                result <= aluRes;
                if (exWb && aluWrites) regFile[exDst] <= aluRes;
                if (exFlagsEn && !aluNop) flags <= aluFlags;
            end
            if (accept) begin
                exValid   <= 1'b1;
                exA       <= opA;
                exB       <= opB;
                exOp      <= op;
                exDst     <= dst_sel;
                exWb      <= wb_en;
                exFlagsEn <= flags_en;
                exCin     <= (op == OP_ADDC) && cinSel;
            end else if (!stall) begin
                exValid <= 1'b0;
            end
        end
    end
endmodule
